// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_mem_pkg
//  Purpose  : Shared definitions for the MEM-stage data memory: Funct3
//             access codes, access-size enum, default widths, and helpers
//             that decode Funct3 into a size and a legality flag.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package riscv_mem_pkg;

    localparam int c_data_w_def = 32;
    localparam int c_addr_w_def = 9;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    // Illegal codes decode to word size; the access is rejected anyway.
    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return MEM_B;
            F3_H, F3_HU: return MEM_H;
            default:     return MEM_W;
        endcase
    endfunction

    // Unsigned variants only make sense for loads, so 1xx stores are illegal.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
               (f3[2] && is_store);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder_if
//  Purpose  : MEM-stage data-memory bus between the core (master) and the
//             data memory responder (slave).
//  Signals  : MemRead, MemWrite, addr, Funct3, wr_data  (master -> slave)
//             rd_data, fault, fault_addr, rd_count, wr_count (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface data_mem_responder_if
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W = c_data_w_def,
    parameter int ADDR_W = c_addr_w_def,
    parameter int CNT_W  = 16
);

    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        Funct3;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output MemRead, MemWrite, addr, Funct3, wr_data,
        input  rd_data, fault, fault_addr, rd_count, wr_count
    );

    modport slave (
        input  MemRead, MemWrite, addr, Funct3, wr_data,
        output rd_data, fault, fault_addr, rd_count, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : store_lane_align
//  Purpose  : Combinational store aligner. Turns Funct3, the byte lane and
//             the store data into a byte-enable mask and lane-replicated
//             write data, and flags a misaligned half/word access.
//  Ports    : i_funct3    access size/sign code
//             i_lane      byte address bits [1:0]
//             i_wr_data   store data (low byte/half used for SB/SH)
//             o_byte_en   one bit per byte lane to write
//             o_lane_data store data replicated into every lane
//             o_misaligned half on odd byte, or word not on lane 0
//  Revision : 1.0  initial release
// ============================================================================
module store_lane_align
    import riscv_mem_pkg::*;
(
    input  wire logic [2:0]  i_funct3,
    input  wire logic [1:0]  i_lane,
    input  wire logic [31:0] i_wr_data,
    output logic      [3:0]  o_byte_en,
    output logic      [31:0] o_lane_data,
    output logic             o_misaligned
);

    mem_size_e w_size;

    assign w_size = f3_size(i_funct3);

    // Replicating the narrow datum into every lane lets the byte enable alone
    // pick where it lands; no barrel shifter is needed.
    always_comb begin
        o_byte_en    = 4'b0000;
        o_lane_data  = i_wr_data;
        o_misaligned = 1'b0;
        case (w_size)
            MEM_B: begin
                o_lane_data = {4{i_wr_data[7:0]}};
                o_byte_en   = 4'b0001 << i_lane;
            end
            MEM_H: begin
                o_lane_data  = {2{i_wr_data[15:0]}};
                o_byte_en    = i_lane[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_lane[0];
            end
            default: begin
                o_lane_data  = i_wr_data;
                o_byte_en    = 4'b1111;
                o_misaligned = (i_lane != 2'b00);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Slave end of the core's MEM-stage port. 2^ADDR_W-byte data
//             memory organised as 32-bit words; byte/half/word stores and
//             sign/zero-extending loads; sticky fault on misaligned or
//             illegal access; saturating load/store counters.
//  Ports    : clk        rising-edge clock
//             reset      synchronous active-high reset (clears all state)
//             bus        data_mem_responder_if.slave:
//                          MemRead/MemWrite/addr/Funct3/wr_data in,
//                          rd_data/fault/fault_addr/rd_count/wr_count out
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W = c_data_w_def,
    parameter int ADDR_W = c_addr_w_def,
    parameter int CNT_W  = 16
)(
    input wire logic      clk,
    input wire logic      reset,
    data_mem_responder_if.slave bus
);

    localparam int c_idx_w = ADDR_W - 2;
    localparam int c_depth = 1 << c_idx_w;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]  r_mem [c_depth];
    logic               r_fault;
    logic [ADDR_W-1:0]  r_fault_addr;
    logic [CNT_W-1:0]   r_rd_count;
    logic [CNT_W-1:0]   r_wr_count;

    logic [c_idx_w-1:0] w_idx;
    logic [1:0]         w_lane;
    logic [3:0]         w_byte_en;
    logic [DATA_W-1:0]  w_lane_data;
    logic               w_misaligned;
    logic               w_illegal;
    logic               w_bad;
    logic               w_do_rd;
    logic               w_do_wr;
    logic [DATA_W-1:0]  w_word;
    logic [DATA_W-1:0]  w_merged;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [DATA_W-1:0]  w_rd_data;

    assign w_idx  = bus.addr[ADDR_W-1:2];
    assign w_lane = bus.addr[1:0];

    store_lane_align u_align (
        .i_funct3     (bus.Funct3),
        .i_lane       (w_lane),
        .i_wr_data    (bus.wr_data),
        .o_byte_en    (w_byte_en),
        .o_lane_data  (w_lane_data),
        .o_misaligned (w_misaligned)
    );

    // A bad access is one that is actually requested and is either
    // misaligned or uses a code that is not allowed for its direction.
    assign w_illegal = f3_illegal(bus.Funct3, bus.MemWrite);
    assign w_bad     = (bus.MemRead || bus.MemWrite) && (w_misaligned || w_illegal);
    assign w_do_rd   = bus.MemRead  && !w_bad;
    assign w_do_wr   = bus.MemWrite && !w_bad;

    // Read port: combinational from the array, so a simultaneous store is
    // not yet visible (pre-write data is returned).
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            2'd3:    w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_rd_data = '0;
        if (w_do_rd) begin
            case (bus.Funct3)
                F3_B:    w_rd_data = {{24{w_byte[7]}}, w_byte};
                F3_BU:   w_rd_data = {24'd0, w_byte};
                F3_H:    w_rd_data = {{16{w_half[15]}}, w_half};
                F3_HU:   w_rd_data = {16'd0, w_half};
                F3_W:    w_rd_data = w_word;
                default: w_rd_data = '0;
            endcase
        end
    end

    // Read-modify-write merge of the enabled lanes into the addressed word.
    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_byte_en[b]) begin
                w_merged[8*b +: 8] = w_lane_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[c_idx_w'(i)] <= '0;
            end
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_rd_count   <= '0;
            r_wr_count   <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[w_idx] <= w_merged;
            end
            if (w_bad) begin
                r_fault <= 1'b1;
                // Only the first offender is recorded.
                if (!r_fault) begin
                    r_fault_addr <= bus.addr;
                end
            end
            if (w_do_rd && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + c_cnt_one;
            end
            if (w_do_wr && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + c_cnt_one;
            end
        end
    end

    assign bus.rd_data    = w_rd_data;
    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;
    assign bus.rd_count   = r_rd_count;
    assign bus.wr_count   = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_responder
//  Purpose  : Self-checking bench for data_mem_responder. The driver applies
//             one bus request per cycle and queues the expected observations;
//             a monitor on the falling edge pops and compares them.
//  Ports    : (none)
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    localparam int K_RD = 0;
    localparam int K_FAULT = 1;
    localparam int K_FADDR = 2;
    localparam int K_RCNT = 3;
    localparam int K_WCNT = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    data_mem_responder_if #(.DATA_W(32), .ADDR_W(9), .CNT_W(16)) bus ();

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RD:    return bus.rd_data;
            K_FAULT: return {31'd0, bus.fault};
            K_FADDR: return {23'd0, bus.fault_addr};
            K_RCNT:  return {16'd0, bus.rd_count};
            default: return {16'd0, bus.wr_count};
        endcase
    endfunction

    // Monitor: every queued expectation refers to the current cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = q.pop_front();
                act = actual(e.kind);
                n_tests++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    task automatic expect_v(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic req(input logic rd, input logic wr, input logic [8:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.addr     = a;
        bus.Funct3   = f3;
        bus.wr_data  = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req(1'b0, 1'b0, 9'h000, F3_W, 32'h0);
        step();
        step();
        reset = 1'b0;

        req(1'b1, 1'b0, 9'h000, F3_W, 32'h0);
        expect_v("reset_lw0", K_RD, 32'h0);
        expect_v("reset_fault", K_FAULT, 32'h0);
        expect_v("reset_faddr", K_FADDR, 32'h0);
        expect_v("reset_rcnt", K_RCNT, 32'h0);
        expect_v("reset_wcnt", K_WCNT, 32'h0);
        step();

        req(1'b0, 1'b1, 9'h010, F3_W, 32'hDEADBEEF);
        expect_v("sw_rd_idle", K_RD, 32'h0);
        step();
        req(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        expect_v("lw_010", K_RD, 32'hDEADBEEF);
        step();
        req(1'b1, 1'b0, 9'h013, F3_B, 32'h0);
        expect_v("lb_013", K_RD, 32'hFFFFFFDE);
        step();
        req(1'b1, 1'b0, 9'h013, F3_BU, 32'h0);
        expect_v("lbu_013", K_RD, 32'h000000DE);
        step();
        req(1'b1, 1'b0, 9'h012, F3_HU, 32'h0);
        expect_v("lhu_012", K_RD, 32'h0000DEAD);
        step();

        req(1'b0, 1'b1, 9'h011, F3_B, 32'hFFFFFF55);
        step();
        req(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        expect_v("lw_after_sb", K_RD, 32'hDEAD55EF);
        step();
        req(1'b0, 1'b1, 9'h012, F3_H, 32'hABCD1234);
        step();
        req(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        expect_v("lw_after_sh", K_RD, 32'h123455EF);
        expect_v("rcnt_6", K_RCNT, 32'd6);
        expect_v("wcnt_3", K_WCNT, 32'd3);
        step();

        // Misaligned word store.
        req(1'b0, 1'b1, 9'h022, F3_W, 32'h11111111);
        expect_v("fault_pre", K_FAULT, 32'h0);
        step();
        req(1'b1, 1'b0, 9'h020, F3_W, 32'h0);
        expect_v("misal_nowrite", K_RD, 32'h0);
        expect_v("fault_set", K_FAULT, 32'h1);
        expect_v("faddr_022", K_FADDR, 32'h022);
        expect_v("misal_wcnt", K_WCNT, 32'd3);
        expect_v("misal_rcnt", K_RCNT, 32'd7);
        step();
        req(1'b1, 1'b0, 9'h031, F3_H, 32'h0);
        expect_v("lh_misal_rd0", K_RD, 32'h0);
        step();
        // Unsigned code used for a store: illegal.
        req(1'b0, 1'b1, 9'h040, F3_BU, 32'h00000077);
        step();
        req(1'b1, 1'b0, 9'h040, 3'b011, 32'h0);
        expect_v("f3_011_rd0", K_RD, 32'h0);
        step();
        req(1'b1, 1'b0, 9'h040, F3_W, 32'h0);
        expect_v("illegal_nowrite", K_RD, 32'h0);
        expect_v("faddr_kept", K_FADDR, 32'h022);
        expect_v("bad_rcnt", K_RCNT, 32'd8);
        expect_v("bad_wcnt", K_WCNT, 32'd3);
        step();

        // Simultaneous read and write: pre-write data returned.
        req(1'b1, 1'b1, 9'h1FC, F3_W, 32'hA5A5A5A5);
        expect_v("rw_old", K_RD, 32'h0);
        step();
        req(1'b1, 1'b0, 9'h1FC, F3_W, 32'h0);
        expect_v("rw_new", K_RD, 32'hA5A5A5A5);
        expect_v("rw_rcnt", K_RCNT, 32'd10);
        expect_v("rw_wcnt", K_WCNT, 32'd4);
        step();
        req(1'b1, 1'b0, 9'h1FC, F3_H, 32'h0);
        expect_v("lh_1fc", K_RD, 32'hFFFFA5A5);
        step();
        req(1'b1, 1'b0, 9'h012, F3_H, 32'h0);
        expect_v("lh_012", K_RD, 32'h00001234);
        step();
        req(1'b1, 1'b0, 9'h010, F3_B, 32'h0);
        expect_v("lb_010", K_RD, 32'hFFFFFFEF);
        step();
        req(1'b1, 1'b0, 9'h011, F3_B, 32'h0);
        expect_v("lb_011", K_RD, 32'h00000055);
        step();

        // Saturate the store counter.
        for (int i = 0; i < 65541; i++) begin
            req(1'b0, 1'b1, 9'h004, F3_W, i);
            step();
        end
        req(1'b1, 1'b0, 9'h004, F3_W, 32'h0);
        expect_v("wcnt_sat", K_WCNT, 32'h0000FFFF);
        expect_v("rcnt_15", K_RCNT, 32'd15);
        expect_v("lw_last_store", K_RD, 32'h00010004);
        expect_v("fault_sticky", K_FAULT, 32'h1);
        step();

        // Store during reset must be dropped.
        reset = 1'b1;
        req(1'b0, 1'b1, 9'h008, F3_W, 32'hCAFEF00D);
        step();
        reset = 1'b0;
        req(1'b1, 1'b0, 9'h008, F3_W, 32'h0);
        expect_v("rst_store_dropped", K_RD, 32'h0);
        expect_v("rst_fault", K_FAULT, 32'h0);
        expect_v("rst_faddr", K_FADDR, 32'h0);
        expect_v("rst_rcnt", K_RCNT, 32'h0);
        expect_v("rst_wcnt", K_WCNT, 32'h0);
        step();
        req(1'b1, 1'b0, 9'h1FC, F3_W, 32'h0);
        expect_v("rst_clear_1fc", K_RD, 32'h0);
        expect_v("rst_rcnt_1", K_RCNT, 32'd1);
        step();
        req(1'b1, 1'b0, 9'h010, F3_W, 32'h0);
        expect_v("rst_clear_010", K_RD, 32'h0);
        step();

        req(1'b0, 1'b0, 9'h000, F3_W, 32'h0);
        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
